// File: rtl/instruction_sequencer.sv
// instruction_sequencer
// Control stage in front of the 8x16 register file and datapath. It holds the
// current instruction in IR, decodes it, and steps a Moore FSM through the
// multi-cycle execute sequence that drives the register-file and datapath
// controls. It also provides the sign-extended immediates taken from IR.
//
// The control outputs are held in a register that is loaded with the decode
// of (next state, next IR). Each control therefore always equals the decode
// of the current state and IR, as a Moore machine requires, and it also
// leaves a flop with no combinational path from the inputs. The one
// exception is write, which is also masked by reset in the same cycle. An
// abandoned write-back must never reach the register file.
module instruction_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    output logic             w,
    output logic [2:0]       readnum,
    output logic [2:0]       writenum,
    output logic             write,
    output logic             loada,
    output logic             loadb,
    output logic             loadc,
    output logic             loads,
    output logic             asel,
    output logic             bsel,
    output logic [1:0]       vsel,
    output logic [1:0]       shift,
    output logic [1:0]       ALUop,
    output logic [WIDTH-1:0] sximm8,
    output logic [WIDTH-1:0] sximm5
);

    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_WRITE_IMM = 3'd2,
        ST_GET_A     = 3'd3,
        ST_GET_B     = 3'd4,
        ST_EXEC      = 3'd5,
        ST_WRITE_REG = 3'd6
    } state_t;

    // One bundle for every control the FSM produces. The bundle is registered as a whole.
    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] vsel;
        logic [1:0] shift;
        logic [1:0] aluop;
    } ctrl_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] ir_r;
    logic [WIDTH-1:0] ir_s;
    ctrl_t            ctrl_r;
    ctrl_t            ctrl_s;

    // Instruction class helpers

    function automatic logic is_mov_imm(input logic [WIDTH-1:0] ir);
        return (ir[15:13] == OPC_MOV) && (ir[12:11] == OP_MOV_IMM);
    endfunction

    function automatic logic is_mov_reg(input logic [WIDTH-1:0] ir);
        return (ir[15:13] == OPC_MOV) && (ir[12:11] == OP_MOV_REG);
    endfunction

    function automatic logic is_alu(input logic [WIDTH-1:0] ir);
        return (ir[15:13] == OPC_ALU);
    endfunction

    function automatic logic is_cmp(input logic [WIDTH-1:0] ir);
        return (ir[15:13] == OPC_ALU) && (ir[12:11] == OP_CMP);
    endfunction

    // Sign extension of the two immediate fields

    function automatic logic [WIDTH-1:0] sext8(input logic [WIDTH-1:0] ir);
        return {{8{ir[7]}}, ir[7:0]};
    endfunction

    function automatic logic [WIDTH-1:0] sext5(input logic [WIDTH-1:0] ir);
        return {{11{ir[4]}}, ir[4:0]};
    endfunction

    // Moore decode: controls that belong to a state and the instruction held in IR.
    // Any control not named for a state stays 0. Register selects are 0 when unused.
    function automatic ctrl_t ctrl_for(input state_t st, input logic [WIDTH-1:0] ir);
        ctrl_t c;
        c = '0;
        case (st)
            ST_WAIT: begin
                c.w = 1'b1;
            end
            ST_DECODE: begin
                c = '0;
            end
            ST_WRITE_IMM: begin
                c.writenum = ir[10:8];
                c.vsel     = 2'b10;
                c.write    = 1'b1;
            end
            ST_GET_A: begin
                c.readnum = ir[10:8];
                c.loada   = 1'b1;
            end
            ST_GET_B: begin
                c.readnum = ir[2:0];
                c.loadb   = 1'b1;
            end
            ST_EXEC: begin
                c.shift = ir[4:3];
                c.bsel  = 1'b0;
                if (is_alu(ir)) begin
                    c.aluop = ir[12:11];
                    c.asel  = 1'b0;
                end else begin
                    // MOV reg: pass the shifted B through as 0 + B.
                    c.aluop = 2'b00;
                    c.asel  = 1'b1;
                end
                if (is_cmp(ir)) begin
                    c.loads = 1'b1;
                    c.loadc = 1'b0;
                end else begin
                    c.loads = 1'b0;
                    c.loadc = 1'b1;
                end
            end
            ST_WRITE_REG: begin
                c.writenum = ir[7:5];
                c.vsel     = 2'b00;
                c.write    = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

    // Next-state selection from the current state and the instruction held in IR
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_WAIT: begin
                if (s) begin
                    state_s = ST_DECODE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DECODE: begin
                if (is_mov_imm(ir_r)) begin
                    state_s = ST_WRITE_IMM;
                end else if (is_mov_reg(ir_r)) begin
                    state_s = ST_GET_B;
                end else if (is_alu(ir_r)) begin
                    state_s = ST_GET_A;
                end else begin
                    // Illegal instruction: return to WAIT with no side effects.
                    state_s = ST_WAIT;
                end
            end
            ST_WRITE_IMM: state_s = ST_WAIT;
            ST_GET_A:     state_s = ST_GET_B;
            ST_GET_B:     state_s = ST_EXEC;
            ST_EXEC: begin
                if (is_cmp(ir_r)) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_WRITE_REG;
                end
            end
            ST_WRITE_REG: state_s = ST_WAIT;
            default:      state_s = ST_WAIT;
        endcase
    end

    // IR load: the new word is accepted only while idle. Loads in other states are dropped.
    always_comb begin
        if ((state_r == ST_WAIT) && load) begin
            ir_s = in;
        end else begin
            ir_s = ir_r;
        end
    end

    // Decode of the next state and IR. The control register loads this at the edge.
    always_comb begin
        ctrl_s = ctrl_for(state_s, ir_s);
    end

    // State, IR and control registers. Reset returns to an idle WAIT with IR cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_WAIT;
            ir_r    <= '0;
            ctrl_r  <= ctrl_for(ST_WAIT, 16'h0000);
        end else begin
            state_r <= state_s;
            ir_r    <= ir_s;
            ctrl_r  <= ctrl_s;
        end
    end

    assign w        = ctrl_r.w;
    assign readnum  = ctrl_r.readnum;
    assign writenum = ctrl_r.writenum;
    // Reset kills a write-back in the same cycle. The register file is never touched by an abandoned instruction.
    assign write    = ctrl_r.write & ~reset;
    assign loada    = ctrl_r.loada;
    assign loadb    = ctrl_r.loadb;
    assign loadc    = ctrl_r.loadc;
    assign loads    = ctrl_r.loads;
    assign asel     = ctrl_r.asel;
    assign bsel     = ctrl_r.bsel;
    assign vsel     = ctrl_r.vsel;
    assign shift    = ctrl_r.shift;
    assign ALUop    = ctrl_r.aluop;
    assign sximm8   = sext8(ir_r);
    assign sximm5   = sext5(ir_r);

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer.
// The bench has three parts:
//   - A per-cycle vector table for the directed instruction walk-throughs.
//   - Hand-written sequences for reset during write-back and for s held high.
//   - Randomised instructions compared against a trace model. The model lists the
//     control vectors each instruction class must produce, in the order they must appear.
module tb_instruction_sequencer;

    logic        clk;
    logic        reset;
    logic        s;
    logic        load;
    logic [15:0] in;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  vsel;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm8;
    logic [15:0] sximm5;

    instruction_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
        .w(w), .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .ALUop(ALUop),
        .sximm8(sximm8), .sximm5(sximm5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] vsel;
        logic [1:0] shift;
        logic [1:0] aluop;
    } ctl_t;

    typedef struct {
        string       name;
        logic        rst;
        logic        s;
        logic        ld;
        logic [15:0] in;
        ctl_t        exp;
        logic [15:0] sx8;
        logic [15:0] sx5;
    } vec_t;

    ctl_t act;
    assign act = {w, readnum, writenum, write, loada, loadb, loadc, loads,
                  asel, bsel, vsel, shift, ALUop};

    int passed = 0;
    int total  = 0;

    // Builds an expected control vector. bsel is always 0.
    function automatic ctl_t mk(input int w_i, input int rn, input int wn, input int wr,
                                input int la, input int lb, input int lc, input int ls,
                                input int as, input int vs, input int sh, input int alu);
        ctl_t c;
        c.w        = w_i[0];
        c.readnum  = rn[2:0];
        c.writenum = wn[2:0];
        c.write    = wr[0];
        c.loada    = la[0];
        c.loadb    = lb[0];
        c.loadc    = lc[0];
        c.loads    = ls[0];
        c.asel     = as[0];
        c.bsel     = 1'b0;
        c.vsel     = vs[1:0];
        c.shift    = sh[1:0];
        c.aluop    = alu[1:0];
        return c;
    endfunction

    task automatic check_ctl(input string name, input ctl_t got, input ctl_t exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: controls got %h expected %h", name, got, exp);
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Trace model: the ordered list of control vectors for one instruction,
    // from DECODE through the return to WAIT.
    task automatic run_instr(input logic [15:0] ir);
        ctl_t        q[$];
        logic [15:0] x8;
        logic [15:0] x5;
        int rn, rd, rm, sh, op;
        rn = int'(ir[10:8]);
        rd = int'(ir[7:5]);
        rm = int'(ir[2:0]);
        sh = int'(ir[4:3]);
        op = int'(ir[12:11]);
        q.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0));
        if (ir[15:13] == 3'b110 && op == 2) begin
            q.push_back(mk(0,0,rd == -1 ? 0 : rn,1,0,0,0,0,0,2,0,0));
        end else if (ir[15:13] == 3'b110 && op == 0) begin
            q.push_back(mk(0,rm,0,0,0,1,0,0,0,0,0,0));
            q.push_back(mk(0,0,0,0,0,0,1,0,1,0,sh,0));
            q.push_back(mk(0,0,rd,1,0,0,0,0,0,0,0,0));
        end else if (ir[15:13] == 3'b101) begin
            q.push_back(mk(0,rn,0,0,1,0,0,0,0,0,0,0));
            q.push_back(mk(0,rm,0,0,0,1,0,0,0,0,0,0));
            q.push_back(mk(0,0,0,0,0,0,(op != 1) ? 1 : 0,(op == 1) ? 1 : 0,0,0,sh,op));
            if (op != 1) q.push_back(mk(0,0,rd,1,0,0,0,0,0,0,0,0));
        end
        q.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0));
        x8 = 16'($signed(ir[7:0]));
        x5 = 16'($signed(ir[4:0]));
        in = ir; load = 1'b1; s = 1'b1;
        for (int k = 0; k < q.size(); k++) begin
            step();
            check_ctl($sformatf("rand_%04h_c%0d", ir, k), act, q[k]);
            check_val($sformatf("rand_%04h_imm%0d", ir, k), {sximm8, sximm5}, {x8, x5});
            if (k < q.size() - 1) begin
                // Busy states must ignore start and load entirely.
                s = 1'($urandom); load = 1'($urandom); in = 16'($urandom);
            end else begin
                s = 1'b0; load = 1'b0;
            end
        end
    endtask

    vec_t tbl[$];
    ctl_t idle_c, zero_c;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [15:0] ir;
        idle_c = mk(1,0,0,0,0,0,0,0,0,0,0,0);
        zero_c = mk(0,0,0,0,0,0,0,0,0,0,0,0);
        // name, reset, s, load, in, expected controls, sximm8, sximm5
        tbl.push_back('{"rst0",      1'b1,1'b0,1'b0,16'h0000, idle_c, 16'h0000,16'h0000});
        tbl.push_back('{"rst1",      1'b1,1'b1,1'b1,16'hFFFF, idle_c, 16'h0000,16'h0000});
        tbl.push_back('{"t1_dec",    1'b0,1'b1,1'b1,16'hD3FB, zero_c, 16'hFFFB,16'hFFFB});
        tbl.push_back('{"t1_wimm",   1'b0,1'b0,1'b0,16'h0000, mk(0,0,3,1,0,0,0,0,0,2,0,0), 16'hFFFB,16'hFFFB});
        tbl.push_back('{"t1_wait",   1'b0,1'b0,1'b0,16'h0000, idle_c, 16'hFFFB,16'hFFFB});
        tbl.push_back('{"t2_dec",    1'b0,1'b1,1'b1,16'hA148, zero_c, 16'h0048,16'h0008});
        tbl.push_back('{"t2_geta",   1'b0,1'b0,1'b0,16'h0000, mk(0,1,0,0,1,0,0,0,0,0,0,0), 16'h0048,16'h0008});
        tbl.push_back('{"t2_getb",   1'b0,1'b0,1'b0,16'h0000, mk(0,0,0,0,0,1,0,0,0,0,0,0), 16'h0048,16'h0008});
        tbl.push_back('{"t2_exec",   1'b0,1'b0,1'b0,16'h0000, mk(0,0,0,0,0,0,1,0,0,0,1,0), 16'h0048,16'h0008});
        tbl.push_back('{"t2_wreg",   1'b0,1'b0,1'b0,16'h0000, mk(0,0,2,1,0,0,0,0,0,0,0,0), 16'h0048,16'h0008});
        tbl.push_back('{"t2_wait",   1'b0,1'b0,1'b0,16'h0000, idle_c, 16'h0048,16'h0008});
        tbl.push_back('{"t3_dec",    1'b0,1'b1,1'b1,16'hA900, zero_c, 16'h0000,16'h0000});
        tbl.push_back('{"t3_geta",   1'b0,1'b0,1'b0,16'h0000, mk(0,1,0,0,1,0,0,0,0,0,0,0), 16'h0000,16'h0000});
        tbl.push_back('{"t3_getb",   1'b0,1'b0,1'b0,16'h0000, mk(0,0,0,0,0,1,0,0,0,0,0,0), 16'h0000,16'h0000});
        tbl.push_back('{"t3_exec",   1'b0,1'b0,1'b0,16'h0000, mk(0,0,0,0,0,0,0,1,0,0,0,1), 16'h0000,16'h0000});
        tbl.push_back('{"t3_wait",   1'b0,1'b0,1'b0,16'h0000, idle_c, 16'h0000,16'h0000});
        tbl.push_back('{"t4_dec",    1'b0,1'b1,1'b1,16'hC0B6, zero_c, 16'hFFB6,16'hFFF6});
        tbl.push_back('{"t4_getb",   1'b0,1'b0,1'b0,16'h0000, mk(0,6,0,0,0,1,0,0,0,0,0,0), 16'hFFB6,16'hFFF6});
        tbl.push_back('{"t4_exec",   1'b0,1'b0,1'b0,16'h0000, mk(0,0,0,0,0,0,1,0,1,0,2,0), 16'hFFB6,16'hFFF6});
        tbl.push_back('{"t4_wreg",   1'b0,1'b0,1'b0,16'h0000, mk(0,0,5,1,0,0,0,0,0,0,0,0), 16'hFFB6,16'hFFF6});
        tbl.push_back('{"t4_wait",   1'b0,1'b0,1'b0,16'h0000, idle_c, 16'hFFB6,16'hFFF6});
        tbl.push_back('{"t5_dec",    1'b0,1'b1,1'b1,16'hE000, zero_c, 16'h0000,16'h0000});
        tbl.push_back('{"t5_wait",   1'b0,1'b0,1'b0,16'h0000, idle_c, 16'h0000,16'h0000});
        tbl.push_back('{"t5b_dec",   1'b0,1'b1,1'b1,16'hA148, zero_c, 16'h0048,16'h0008});
        tbl.push_back('{"t5b_geta",  1'b0,1'b0,1'b0,16'h0000, mk(0,1,0,0,1,0,0,0,0,0,0,0), 16'h0048,16'h0008});
        tbl.push_back('{"t5b_getb",  1'b0,1'b0,1'b0,16'h0000, mk(0,0,0,0,0,1,0,0,0,0,0,0), 16'h0048,16'h0008});
        tbl.push_back('{"t5b_exec",  1'b0,1'b0,1'b1,16'h1234, mk(0,0,0,0,0,0,1,0,0,0,1,0), 16'h0048,16'h0008});
        tbl.push_back('{"t5b_wreg",  1'b0,1'b0,1'b0,16'h0000, mk(0,0,2,1,0,0,0,0,0,0,0,0), 16'h0048,16'h0008});
        tbl.push_back('{"t5b_wait",  1'b0,1'b0,1'b0,16'h0000, idle_c, 16'h0048,16'h0008});

        reset = 1'b1; s = 1'b0; load = 1'b0; in = 16'h0000;
        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst; s = tbl[i].s; load = tbl[i].ld; in = tbl[i].in;
            step();
            check_ctl(tbl[i].name, act, tbl[i].exp);
            check_val({tbl[i].name, "_imm"}, {sximm8, sximm5}, {tbl[i].sx8, tbl[i].sx5});
        end

        // Reset arriving during WRITE_REG of ADD R2,R1,R0,LSL#1
        reset = 1'b0; s = 1'b1; load = 1'b1; in = 16'hA148;
        step();
        s = 1'b0; load = 1'b0;
        step(); step(); step(); step();
        check_ctl("t6_wreg", act, mk(0,0,2,1,0,0,0,0,0,0,0,0));
        reset = 1'b1;
        #1;
        check_val("t6_write_gated", {31'd0, write}, 32'd0);
        step();
        reset = 1'b0;
        check_ctl("t6_after_reset", act, idle_c);
        check_val("t6_ir_cleared", {sximm8, sximm5}, 32'd0);

        // s held high: WAIT lasts a single cycle before re-executing the same IR
        s = 1'b1; load = 1'b1; in = 16'hD3FB;
        step();
        check_ctl("hold_dec1", act, zero_c);
        load = 1'b0;
        step();
        check_ctl("hold_wimm1", act, mk(0,0,3,1,0,0,0,0,0,2,0,0));
        step();
        check_ctl("hold_wait", act, idle_c);
        step();
        check_ctl("hold_dec2", act, zero_c);
        s = 1'b0;
        step();
        check_ctl("hold_wimm2", act, mk(0,0,3,1,0,0,0,0,0,2,0,0));
        step();
        check_ctl("hold_wait2", act, idle_c);

        // Randomised instructions, biased toward the legal opcodes
        for (int n = 0; n < 150; n++) begin
            r  = $urandom;
            ir = r[15:0];
            case ($urandom_range(0, 3))
                0:       ir[15:13] = 3'b110;
                1, 2:    ir[15:13] = 3'b101;
                default: ir = ir;
            endcase
            run_instr(ir);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
